mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
Data-memory side of the core's load/store control. Consumes the per-instruction access request (byte-enable mask, read/write, sign-extend flag, effective address, store data) and runs it as one or two word-aligned transactions on a req/ack data bus. Returns aligned and extended load data to writeback. Drives busy back to the core as a pipeline stall.

Parameters:
TIMEOUT_CYCLES, 255, bus watchdog limit per beat; 0 disables the watchdog.
ADDR_W, 32, address width.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request strobe from core; honoured only while idle
we  in  1  1 = store, 0 = load
iobytes  in  4  size mask: 0001 byte, 0011 half, 1111 word, 0000 no access
sext  in  1  sign-extend load data (byte/half only)
addr  in  ADDR_W  effective byte address
wdata  in  32  store data, right-justified
busy  out  1  request in flight; core stalls
done  out  1  one-cycle completion pulse
fault  out  1  qualifies done: misaligned (feature off) or watchdog expiry
rdata  out  32  load result; valid with done, held until next done
bus_req  out  1  bus request, held until bus_ack
bus_we  out  1  bus write
bus_addr  out  ADDR_W  word-aligned address (bits 1:0 = 0)
bus_be  out  4  byte lane enables
bus_wdata  out  32  lane-aligned write data
bus_ack  in  1  beat accepted/complete; ignored while bus_req = 0
bus_rdata  in  32  read data, valid with bus_ack

Behaviour:
- Reset (asynchronous, immediate, mid-transaction included): state IDLE. All outputs 0, rdata 0, watchdog cleared.
- FSM states: IDLE, BEAT0, BEAT1, RESP.
- IDLE: on start, latch all inputs and go to BEAT0. Exceptions, both going straight to RESP with no bus activity:
  - iobytes = 0000.
  - Misaligned access with MISALIGNED_SPLIT_EN undefined; fault = 1.
- start is ignored outside IDLE. busy = (state != IDLE).
- Offset o = addr[1:0]. Misaligned when o + size > 4, i.e. half at o = 3, or word at o != 0.
- Lane math:
  - Shift the 8-bit mask {0000, iobytes} left by o; low nibble gives beat-0 bus_be, high nibble gives beat-1 bus_be.
  - Shift the 64-bit {32'b0, wdata} left by 8*o; low word gives beat-0 bus_wdata, high word gives beat-1 bus_wdata.
- BEAT0: bus_req = 1, bus_addr = {addr[31:2], 2'b00}. On bus_ack, capture bus_rdata. Go to BEAT1 if the high nibble of the mask is non-zero, else RESP.
- BEAT1: bus_req = 1, bus_addr = beat-0 address + 4; 32-bit wrap from 0xFFFFFFFC to 0x00000000 is permitted. On bus_ack, capture data and go to RESP.
- bus_req and bus outputs are registered and stable while bus_req = 1. bus_req falls the cycle after ack; there is no bus_req=0 gap between BEAT0 and BEAT1 beats.
- RESP: done = 1 for one cycle, then IDLE.
  - Load rdata: shift {beat1, beat0} right by 8*o, then mask to size.
  - If sext, replicate bit 7 (byte) or bit 15 (half). Word ignores sext.
  - Stores: rdata unchanged.
- Latency, zero-wait bus: start at cycle t, bus_req at t+1, ack at t+1, done at t+2. A split access adds 1 cycle. A no-access request gives done at t+1.
- Watchdog: counts cycles in BEAT0/BEAT1 and resets each beat. When it reaches TIMEOUT_CYCLES without ack: drop bus_req, go to RESP with fault = 1, rdata unchanged.
- An ack arriving in the same cycle as expiry wins; no fault is raised.

Optional Feature:
MISALIGNED_SPLIT_EN
- Defined: misaligned accesses split into two beats as above.
- Undefined: BEAT1 logic is omitted, and misaligned requests finish with done = 1, fault = 1, no bus_req, rdata unchanged.

Decomposition:
- Package mau_pkg:
  - State enum encodings (IDLE = 0, BEAT0, BEAT1, RESP).
  - IOB_NONE / IOB_BYTE / IOB_HALF / IOB_WORD constants (0000 / 0001 / 0011 / 1111).
- Sub-module mau_align: purely combinational lane shift of be/wdata, and load extract/mask/sign-extend. Instantiated once; FSM and watchdog stay in the top.

Test Plan:
- Signed byte load: iobytes 0001, sext 1, addr 0x103, bus_rdata 0x80123456 with immediate ack -> bus_addr 0x100, bus_be 1000, done 2 cycles after start, rdata 0xFFFFFF80, fault 0.
- Halfword store: we 1, iobytes 0011, addr 0x202, wdata 0x0000BEEF -> bus_we 1, bus_be 1100, bus_wdata 0xBEEF0000; done after ack.
- Misaligned word load at addr 0x101:
  - Split build: beats at 0x100 be 1110 and 0x104 be 0001, bus_rdata 0x332211AA then 0xBBBBBB44 -> rdata 0x44332211, done 3 cycles after start.
  - Non-split build: no bus_req, done = fault = 1 one cycle after start.
- Watchdog: TIMEOUT_CYCLES 4, bus_ack held 0 -> bus_req high exactly 4 cycles, then done = fault = 1; a second start is accepted the following cycle.
- Reset mid-beat: rst_n low while bus_req = 1 and awaiting ack -> bus_req, busy, done drop asynchronously. After release, a late bus_ack is ignored and no done is produced.
- No-access and stall: iobytes 0000 -> done next cycle, no bus_req. A start pulsed while busy is dropped, with no second transaction.

Source files
------------

// File: rtl/mau_pkg.sv
// Shared types and constants for the memory access unit.
package mau_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [3:0] IOB_NONE = 4'b0000;
    localparam logic [3:0] IOB_BYTE = 4'b0001;
    localparam logic [3:0] IOB_HALF = 4'b0011;
    localparam logic [3:0] IOB_WORD = 4'b1111;

endpackage

// File: rtl/mau_align.sv
// Combinational lane alignment: store be/wdata shifted onto bus lanes,
// load data shifted down, masked to size and optionally sign-extended.
module mau_align
    import mau_pkg::*;
(
    input  logic [1:0]  st_off,
    input  logic [3:0]  st_iobytes,
    input  logic [31:0] st_wdata,
    output logic [3:0]  be_lo,
    output logic [3:0]  be_hi,
    output logic [31:0] wdata_lo,
    output logic [31:0] wdata_hi,
    input  logic [1:0]  ld_off,
    input  logic [3:0]  ld_iobytes,
    input  logic        ld_sext,
    input  logic [63:0] ld_data,
    output logic [31:0] ld_result
);

    function automatic logic [31:0] size_extend(input logic [31:0] w,
                                                input logic [3:0]  iob,
                                                input logic        sx);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        b = w[7:0];
        h = w[15:0];
        case (iob)
            IOB_BYTE: size_extend = sx ? 32'(b) : {24'b0, w[7:0]};
            IOB_HALF: size_extend = sx ? 32'(h) : {16'b0, w[15:0]};
            IOB_WORD: size_extend = w;
            default:  size_extend = 32'b0;
        endcase
    endfunction

    logic [7:0]  be_wide;
    logic [63:0] wd_wide;
    logic [31:0] ld_word;

    assign be_wide  = {4'b0000, st_iobytes} << st_off;
    assign wd_wide  = {32'b0, st_wdata} << {st_off, 3'b000};
    assign be_lo    = be_wide[3:0];
    assign be_hi    = be_wide[7:4];
    assign wdata_lo = wd_wide[31:0];
    assign wdata_hi = wd_wide[63:32];

    // The two beats arrive as {beat1, beat0}; the access starts at byte ld_off.
    assign ld_word   = 32'(ld_data >> {ld_off, 3'b000});
    assign ld_result = size_extend(ld_word, ld_iobytes, ld_sext);

endmodule

// File: rtl/mem_access_unit.sv
// Load/store bus sequencer: one or two word-aligned req/ack beats per access.
// Define MISALIGNED_SPLIT_EN to split misaligned accesses; otherwise they fault.
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int ADDR_W         = 32
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              we,
    input  logic [3:0]        iobytes,
    input  logic              sext,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic              fault,
    output logic [31:0]       rdata,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [31:0]       bus_wdata,
    input  logic              bus_ack,
    input  logic [31:0]       bus_rdata
);

    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_t      state, next_state;
    logic [3:0]  be_lo, be_hi;
    logic [31:0] wd_lo, wd_hi, ld_result;
    logic [63:0] ld_data;
    logic        ack, expire;
    logic        req_d, done_d, fault_d, load_upd;
    logic [WD_W-1:0] wd_cnt;

    logic        we_q, sext_q;
    logic [3:0]  iob_q;
    logic [1:0]  off_q;

`ifdef MISALIGNED_SPLIT_EN
    logic [3:0]  be1_q;
    logic [31:0] wd1_q, beat0_q;
    assign ld_data = (state == BEAT1) ? {bus_rdata, beat0_q} : {32'b0, bus_rdata};
`else
    logic misaligned;
    logic unused_hi;
    assign misaligned = (be_hi != 4'b0000);
    assign unused_hi  = ^wd_hi;
    assign ld_data    = {32'b0, bus_rdata};
`endif

    mau_align u_align (
        .st_off     (addr[1:0]),
        .st_iobytes (iobytes),
        .st_wdata   (wdata),
        .be_lo      (be_lo),
        .be_hi      (be_hi),
        .wdata_lo   (wd_lo),
        .wdata_hi   (wd_hi),
        .ld_off     (off_q),
        .ld_iobytes (iob_q),
        .ld_sext    (sext_q),
        .ld_data    (ld_data),
        .ld_result  (ld_result)
    );

    assign busy   = (state != IDLE);
    assign ack    = bus_ack & bus_req;
    assign expire = (TIMEOUT_CYCLES != 0) && (wd_cnt == WD_LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // An ack in the expiry cycle takes priority over the watchdog.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (iobytes == IOB_NONE) next_state = RESP;
`ifndef MISALIGNED_SPLIT_EN
                    else if (misaligned)     next_state = RESP;
`endif
                    else                     next_state = BEAT0;
                end
            end
            BEAT0: begin
`ifdef MISALIGNED_SPLIT_EN
                if (ack)         next_state = (be1_q != 4'b0000) ? BEAT1 : RESP;
`else
                if (ack)         next_state = RESP;
`endif
                else if (expire) next_state = RESP;
            end
`ifdef MISALIGNED_SPLIT_EN
            BEAT1: begin
                if (ack || expire) next_state = RESP;
            end
`endif
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        req_d    = (next_state == BEAT0) || (next_state == BEAT1);
        done_d   = (next_state == RESP);
        fault_d  = done_d &&
                   ((state == IDLE && iobytes != IOB_NONE) ||
                    ((state == BEAT0 || state == BEAT1) && !ack));
        load_upd = done_d && ack && !we_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_be    <= 4'b0000;
            bus_wdata <= 32'b0;
            done      <= 1'b0;
            fault     <= 1'b0;
            rdata     <= 32'b0;
            wd_cnt    <= '0;
        end else begin
            bus_req <= req_d;
            done    <= done_d;
            fault   <= fault_d;
            if (load_upd) rdata <= ld_result;

            if (req_d) wd_cnt <= (next_state == state) ? wd_cnt + WD_W'(1) : '0;
            else       wd_cnt <= '0;

            if (state == IDLE && next_state == BEAT0) begin
                bus_we    <= we;
                bus_addr  <= {addr[ADDR_W-1:2], 2'b00};
                bus_be    <= be_lo;
                bus_wdata <= wd_lo;
`ifdef MISALIGNED_SPLIT_EN
            end else if (state == BEAT0 && next_state == BEAT1) begin
                bus_addr  <= bus_addr + ADDR_W'(4);
                bus_be    <= be1_q;
                bus_wdata <= wd1_q;
`endif
            end else if (!req_d) begin
                bus_we    <= 1'b0;
                bus_addr  <= '0;
                bus_be    <= 4'b0000;
                bus_wdata <= 32'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            we_q   <= we;
            iob_q  <= iobytes;
            sext_q <= sext;
            off_q  <= addr[1:0];
`ifdef MISALIGNED_SPLIT_EN
            be1_q  <= be_hi;
            wd1_q  <= wd_hi;
`endif
        end
`ifdef MISALIGNED_SPLIT_EN
        if (state == BEAT0 && ack) beat0_q <= bus_rdata;
`endif
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: transaction-level model plus bus responder.
`timescale 1ns/1ps
module tb_mem_access_unit;

    localparam int TMO = 4;
`ifdef MISALIGNED_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, we = 1'b0, sext = 1'b0;
    logic [3:0]  iobytes = 4'b0;
    logic [31:0] addr = 32'b0, wdata = 32'b0;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = 32'b0;
    logic        busy, done, fault, bus_req, bus_we;
    logic [31:0] rdata, bus_addr, bus_wdata;
    logic [3:0]  bus_be;

    mem_access_unit #(.TIMEOUT_CYCLES(TMO), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .we(we), .iobytes(iobytes),
        .sext(sext), .addr(addr), .wdata(wdata), .busy(busy), .done(done),
        .fault(fault), .rdata(rdata), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Expected transaction, filled by predict()
    int          exp_nbeats, exp_lat, exp_reqs, exp_acks;
    logic [31:0] exp_addr [2];
    logic [3:0]  exp_be [2];
    logic [31:0] exp_wd [2];
    logic        exp_we, exp_fault, exp_upd;
    logic [31:0] exp_load;
    int          rsp_d [2];
    logic [31:0] rsp_data [2];

    int          cyc = 0, t0 = 0, cbeat = 0, bwait = 0, reqs = 0;
    logic        pend = 1'b0, force_ack = 1'b0;
    logic [31:0] model_rdata = 32'b0;
    logic [31:0] seen_addr [2];
    logic [3:0]  seen_be [2];
    logic [31:0] seen_wd [2];

    task automatic predict(input logic w, input logic [3:0] iob, input logic sx,
                           input logic [31:0] a, input logic [31:0] wd);
        int          o, p;
        logic [7:0]  bytes [8];
        logic [3:0]  be [2];
        logic [31:0] lanes [2];
        logic [31:0] res;
        o = int'(a[1:0]);
        be[0] = 4'b0; be[1] = 4'b0; lanes[0] = 32'b0; lanes[1] = 32'b0;
        for (int i = 0; i < 4; i++) begin
            if (iob[i]) begin
                p = o + i;
                be[p / 4][p % 4] = 1'b1;
                lanes[p / 4][8 * (p % 4) +: 8] = wd[8 * i +: 8];
            end
        end
        exp_we = w;
        exp_addr[0] = {a[31:2], 2'b00};
        exp_addr[1] = exp_addr[0] + 32'd4;
        exp_be = be;
        exp_wd = lanes;
        exp_fault = 1'b0; exp_upd = 1'b0; exp_load = 32'b0;
        exp_reqs = 0; exp_acks = 0; exp_lat = 1; exp_nbeats = 0;
        if (iob == 4'b0000) begin
            exp_nbeats = 0;
        end else if (be[1] != 4'b0 && !SPLIT) begin
            exp_fault = 1'b1;
        end else begin
            exp_nbeats = (be[1] != 4'b0) ? 2 : 1;
            for (int k = 0; k < exp_nbeats && !exp_fault; k++) begin
                if (rsp_d[k] >= TMO) begin
                    exp_reqs += TMO; exp_lat += TMO; exp_fault = 1'b1;
                end else begin
                    exp_reqs += rsp_d[k] + 1; exp_lat += rsp_d[k] + 1; exp_acks++;
                end
            end
            if (!exp_fault && !w) begin
                for (int i = 0; i < 4; i++) begin
                    bytes[i]     = rsp_data[0][8 * i +: 8];
                    bytes[i + 4] = rsp_data[1][8 * i +: 8];
                end
                res = 32'b0;
                for (int i = 0; i < 4; i++) if (iob[i]) res[8 * i +: 8] = bytes[o + i];
                if (sx && iob == 4'b0001 && res[7])  res[31:8]  = 24'hFFFFFF;
                if (sx && iob == 4'b0011 && res[15]) res[31:16] = 16'hFFFF;
                exp_upd = 1'b1;
                exp_load = res;
            end
        end
    endtask

    // Bus responder and per-cycle compare against the model
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend = 1'b0; cbeat = 0; bwait = 0; reqs = 0;
                model_rdata = 32'b0; bus_ack = 1'b0;
            end else begin
                cyc++;
                chk("busy", 32'(busy), 32'(pend));
                if (bus_req) begin
                    reqs++;
                    if (!pend || cbeat >= exp_nbeats) begin
                        chk("unexpected_bus_req", 32'(bus_req), 32'd0);
                        bus_ack = 1'b0;
                    end else begin
                        chk("bus_addr", bus_addr, exp_addr[cbeat]);
                        chk("bus_be", 32'(bus_be), 32'(exp_be[cbeat]));
                        chk("bus_we", 32'(bus_we), 32'(exp_we));
                        if (exp_we) chk("bus_wdata", bus_wdata, exp_wd[cbeat]);
                        seen_addr[cbeat] = bus_addr;
                        seen_be[cbeat]   = bus_be;
                        seen_wd[cbeat]   = bus_wdata;
                        if (bwait >= rsp_d[cbeat]) begin
                            bus_ack = 1'b1; bus_rdata = rsp_data[cbeat];
                            cbeat++; bwait = 0;
                        end else begin
                            bus_ack = 1'b0; bus_rdata = 32'hDEAD_BEEF; bwait++;
                        end
                    end
                end else begin
                    bus_ack = force_ack;
                end
                if (done) begin
                    chk("done_expected", 32'(pend), 32'd1);
                    if (pend) begin
                        chk("latency", 32'(cyc - t0), 32'(exp_lat));
                        chk("fault", 32'(fault), 32'(exp_fault));
                        chk("req_cycles", 32'(reqs), 32'(exp_reqs));
                        chk("acked_beats", 32'(cbeat), 32'(exp_acks));
                        if (exp_upd) model_rdata = exp_load;
                        chk("rdata", rdata, model_rdata);
                    end
                    pend = 1'b0;
                end
                if (start && !busy) begin
                    pend = 1'b1; t0 = cyc; cbeat = 0; bwait = 0; reqs = 0;
                end
            end
        end
    end

    task automatic run(input logic w, input logic [3:0] iob, input logic sx,
                       input logic [31:0] a, input logic [31:0] wd,
                       input int d0, input int d1,
                       input logic [31:0] r0, input logic [31:0] r1, input bit poke);
        int n;
        rsp_d[0] = d0; rsp_d[1] = d1; rsp_data[0] = r0; rsp_data[1] = r1;
        predict(w, iob, sx, a, wd);
        we = w; iobytes = iob; sext = sx; addr = a; wdata = wd; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        if (poke) begin
            we = ~w; iobytes = 4'b1111; addr = 32'h0000_0F00; start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
        end
        n = 0;
        while (pend && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        if (pend) chk("txn_completes", 32'(pend), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not reach its summary");
        $fatal(1, "bench hung");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_bus_req", 32'(bus_req), 32'd0);
        chk("rst_bus_be", 32'(bus_be), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // signed byte load at offset 3: byte 0x80 -> 0xFFFFFF80
        run(1'b0, 4'b0001, 1'b1, 32'h0000_0103, 32'h0, 0, 0, 32'h8012_3456, 32'h0, 1'b0);
        chk("lit_sbyte_rdata", rdata, 32'hFFFF_FF80);
        chk("lit_sbyte_addr", seen_addr[0], 32'h0000_0100);
        chk("lit_sbyte_be", 32'(seen_be[0]), 32'b1000);

        // halfword store at offset 2
        run(1'b1, 4'b0011, 1'b0, 32'h0000_0202, 32'h0000_BEEF, 0, 0, 32'h0, 32'h0, 1'b0);
        chk("lit_hstore_wdata", seen_wd[0], 32'hBEEF_0000);
        chk("lit_hstore_be", 32'(seen_be[0]), 32'b1100);
        chk("lit_hstore_rdata_held", rdata, 32'hFFFF_FF80);

        // misaligned word load at 0x101
        run(1'b0, 4'b1111, 1'b0, 32'h0000_0101, 32'h0, 0, 0, 32'h3322_11AA, 32'hBBBB_BB44, 1'b0);
`ifdef MISALIGNED_SPLIT_EN
        chk("lit_split_rdata", rdata, 32'h4433_2211);
        chk("lit_split_be0", 32'(seen_be[0]), 32'b1110);
        chk("lit_split_be1", 32'(seen_be[1]), 32'b0001);
        chk("lit_split_addr1", seen_addr[1], 32'h0000_0104);
`else
        chk("lit_misalign_rdata_held", rdata, 32'hFFFF_FF80);
`endif

        // half loads, unsigned then signed: bytes CD,AB
        run(1'b0, 4'b0011, 1'b0, 32'h0000_0002, 32'h0, 0, 0, 32'hABCD_1234, 32'h0, 1'b0);
        chk("lit_uhalf_rdata", rdata, 32'h0000_ABCD);
        run(1'b0, 4'b0011, 1'b1, 32'h0000_0002, 32'h0, 0, 0, 32'hABCD_1234, 32'h0, 1'b0);
        chk("lit_shalf_rdata", rdata, 32'hFFFF_ABCD);

        // word load ignores sext
        run(1'b0, 4'b1111, 1'b1, 32'h0000_0010, 32'h0, 0, 0, 32'h8765_4321, 32'h0, 1'b0);
        // byte load with two wait states
        run(1'b0, 4'b0001, 1'b0, 32'h0000_0041, 32'h0, 2, 0, 32'h0000_A500, 32'h0, 1'b0);
        chk("lit_wait_byte_rdata", rdata, 32'h0000_00A5);

        // ack in the watchdog's final cycle: no fault
        run(1'b1, 4'b1111, 1'b0, 32'h0000_0300, 32'h1234_5678, TMO - 1, 0, 32'h0, 32'h0, 1'b0);
        // no ack: watchdog fires, then an immediate no-access request
        run(1'b0, 4'b1111, 1'b0, 32'h0000_0400, 32'h0, 50, 0, 32'h1111_1111, 32'h0, 1'b0);
        chk("lit_timeout_rdata_held", rdata, 32'h0000_00A5);
        run(1'b0, 4'b0000, 1'b0, 32'h0000_0500, 32'h0, 0, 0, 32'h2222_2222, 32'h0, 1'b0);

        // start pulsed while busy must be dropped
        run(1'b0, 4'b0001, 1'b0, 32'h0000_0500, 32'h0, 2, 0, 32'h0000_007F, 32'h0, 1'b1);
        chk("lit_stall_rdata", rdata, 32'h0000_007F);

        // half across the top of the address space, sign-extended 0xF312
        run(1'b0, 4'b0011, 1'b1, 32'hFFFF_FFFF, 32'h0, 0, 0, 32'h1200_0000, 32'h0000_00F3, 1'b0);
        // split word with second beat timing out
        run(1'b0, 4'b1111, 1'b0, 32'h0000_0206, 32'h0, 0, 50, 32'h5555_5555, 32'h6666_6666, 1'b0);

        // reset while a beat awaits ack
        rsp_d[0] = 100; rsp_d[1] = 0; rsp_data[0] = 32'h0; rsp_data[1] = 32'h0;
        predict(1'b0, 4'b1111, 1'b0, 32'h0000_0700, 32'h0);
        we = 1'b0; iobytes = 4'b1111; sext = 1'b0; addr = 32'h0000_0700; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_bus_req", 32'(bus_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_bus_req", 32'(bus_req), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_done", 32'(done), 32'd0);
        chk("async_rst_rdata", rdata, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1; force_ack = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        force_ack = 1'b0;
        chk("late_ack_done", 32'(done), 32'd0);
        chk("late_ack_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;

        // normal operation after reset
        run(1'b0, 4'b0001, 1'b1, 32'h0000_0800, 32'h0, 0, 0, 32'h0000_0042, 32'h0, 1'b0);
        chk("lit_post_rst_rdata", rdata, 32'h0000_0042);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
